// File: rtl/alu_ctrl_exwb_if.sv
// Bus bundle between the ID/EX buffer, the execute slice and the write-back stage.
// The slave modport is the execute slice; the master modport is its surroundings.
interface alu_ctrl_exwb_if #(
    parameter int DW = 32,
    parameter int RW = 6
);
    logic [3:0]    opcode;
    logic          RegWrt, MemToReg, PCtoReg, MemRead, MemWrt;
    logic          BranchNeg, BranchZero, Jump, JumpMem;
    logic [3:0]    ALUOp;

    logic          RegWrt_i, MemToReg_i, PCtoReg_i, BranchNeg_i, BranchZero_i, Jump_i, JumpMem_i;
    logic [3:0]    ALUOp_i;
    logic [DW-1:0] A, B;
    logic [DW-1:0] ALUout;
    logic          Z_flag, N_flag;
    logic [DW-1:0] Dmem_i, SEadd_i;
    logic [RW-1:0] Rd_i;

    logic          RegWrt_EXWB, MemToReg_EXWB, PCtoReg_EXWB, BranchNeg_EXWB;
    logic          BranchZero_EXWB, Jump_EXWB, JumpMem_EXWB;
    logic [DW-1:0] ALUout_EXWB, Dmemout_EXWB, SEadderout_EXWB;
    logic [RW-1:0] Rd_EXWB;
    logic          Z_EXWB, N_EXWB;

    modport master (
        output opcode,
        output RegWrt_i, MemToReg_i, PCtoReg_i, BranchNeg_i, BranchZero_i, Jump_i, JumpMem_i,
        output ALUOp_i, A, B, Dmem_i, SEadd_i, Rd_i,
        input  RegWrt, MemToReg, PCtoReg, MemRead, MemWrt, BranchNeg, BranchZero, Jump, JumpMem,
        input  ALUOp, ALUout, Z_flag, N_flag,
        input  RegWrt_EXWB, MemToReg_EXWB, PCtoReg_EXWB, BranchNeg_EXWB, BranchZero_EXWB,
        input  Jump_EXWB, JumpMem_EXWB, ALUout_EXWB, Dmemout_EXWB, SEadderout_EXWB,
        input  Rd_EXWB, Z_EXWB, N_EXWB
    );

    modport slave (
        input  opcode,
        input  RegWrt_i, MemToReg_i, PCtoReg_i, BranchNeg_i, BranchZero_i, Jump_i, JumpMem_i,
        input  ALUOp_i, A, B, Dmem_i, SEadd_i, Rd_i,
        output RegWrt, MemToReg, PCtoReg, MemRead, MemWrt, BranchNeg, BranchZero, Jump, JumpMem,
        output ALUOp, ALUout, Z_flag, N_flag,
        output RegWrt_EXWB, MemToReg_EXWB, PCtoReg_EXWB, BranchNeg_EXWB, BranchZero_EXWB,
        output Jump_EXWB, JumpMem_EXWB, ALUout_EXWB, Dmemout_EXWB, SEadderout_EXWB,
        output Rd_EXWB, Z_EXWB, N_EXWB
    );
endinterface

// File: rtl/alu_ctrl_exwb.sv
// Execute-side CPU slice: ID-stage opcode decoder, EX-stage ALU and the EX/WB
// pipeline register with sticky Z/N flags consumed by later BRZ/BRN.
module alu_ctrl_exwb #(
    parameter int DW = 32,
    parameter int RW = 6
) (
    input logic               clk,
    input logic               rst_n,
    alu_ctrl_exwb_if.slave    bus
);
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam logic [DW-1:0] ONE_W  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_W = {DW{1'b0}};

    // Control vector order: RegWrt MemToReg PCtoReg MemRead MemWrt BranchNeg BranchZero Jump JumpMem
    logic [8:0]    ctrl_s;
    logic [3:0]    alu_op_s;
    logic [DW-1:0] alu_s;
    logic          z_s, n_s, flag_ld_s;

    logic [6:0]    ctrl_d, ctrl_q;
    logic [DW-1:0] alu_out_d, alu_out_q, dmem_d, dmem_q, seadd_d, seadd_q;
    logic [RW-1:0] rd_d, rd_q;
    logic          z_d, z_q, n_d, n_q;

    // Opcode decoder (ID stage)
    always_comb begin
        ctrl_s   = 9'b0_0000_0000;
        alu_op_s = OP_NOP;
        case (bus.opcode)
            OP_SVPC: ctrl_s = 9'b1_0100_0000;
            OP_LD:   ctrl_s = 9'b1_1010_0000;
            OP_ST:   ctrl_s = 9'b0_0001_0000;
            OP_ADD, OP_INC, OP_NEG, OP_SUB: begin
                ctrl_s   = 9'b1_0000_0000;
                alu_op_s = bus.opcode;
            end
            OP_J:    ctrl_s = 9'b0_0000_0010;
            OP_BRZ:  ctrl_s = 9'b0_0000_0100;
            OP_BRN:  ctrl_s = 9'b0_0000_1000;
            OP_JM:   ctrl_s = 9'b0_0010_0001;
            default: ctrl_s = 9'b0_0000_0000;
        endcase
    end

    assign {bus.RegWrt, bus.MemToReg, bus.PCtoReg, bus.MemRead, bus.MemWrt,
            bus.BranchNeg, bus.BranchZero, bus.Jump, bus.JumpMem} = ctrl_s;
    assign bus.ALUOp = alu_op_s;

    // ALU (EX stage); every non-arithmetic operation passes A through
    always_comb begin
        alu_s = bus.A;
        case (bus.ALUOp_i)
            OP_ADD:  alu_s = bus.A + bus.B;
            OP_INC:  alu_s = bus.A + ONE_W;
            OP_NEG:  alu_s = ~bus.A + ONE_W;
            OP_SUB:  alu_s = bus.A - bus.B;
            default: alu_s = bus.A;
        endcase
    end

    assign z_s         = (alu_s == ZERO_W);
    assign n_s         = alu_s[DW-1];
    assign bus.ALUout  = alu_s;
    assign bus.Z_flag  = z_s;
    assign bus.N_flag  = n_s;

    // Next-state for the EX/WB register; flags only follow arithmetic results
    always_comb begin
        flag_ld_s = (bus.ALUOp_i == OP_ADD) || (bus.ALUOp_i == OP_INC) ||
                    (bus.ALUOp_i == OP_NEG) || (bus.ALUOp_i == OP_SUB);
        ctrl_d    = {bus.RegWrt_i, bus.MemToReg_i, bus.PCtoReg_i, bus.BranchNeg_i,
                     bus.BranchZero_i, bus.Jump_i, bus.JumpMem_i};
        alu_out_d = alu_s;
        dmem_d    = bus.Dmem_i;
        seadd_d   = bus.SEadd_i;
        rd_d      = bus.Rd_i;
        if (flag_ld_s) begin
            z_d = z_s;
            n_d = n_s;
        end else begin
            z_d = z_q;
            n_d = n_q;
        end
    end

    // EX/WB register; reset yields a bubble (no write, no jump)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= 7'b000_0000;
            alu_out_q <= ZERO_W;
            dmem_q    <= ZERO_W;
            seadd_q   <= ZERO_W;
            rd_q      <= {RW{1'b0}};
            z_q       <= 1'b0;
            n_q       <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            alu_out_q <= alu_out_d;
            dmem_q    <= dmem_d;
            seadd_q   <= seadd_d;
            rd_q      <= rd_d;
            z_q       <= z_d;
            n_q       <= n_d;
        end
    end

    assign {bus.RegWrt_EXWB, bus.MemToReg_EXWB, bus.PCtoReg_EXWB, bus.BranchNeg_EXWB,
            bus.BranchZero_EXWB, bus.Jump_EXWB, bus.JumpMem_EXWB} = ctrl_q;
    assign bus.ALUout_EXWB     = alu_out_q;
    assign bus.Dmemout_EXWB    = dmem_q;
    assign bus.SEadderout_EXWB = seadd_q;
    assign bus.Rd_EXWB         = rd_q;
    assign bus.Z_EXWB          = z_q;
    assign bus.N_EXWB          = n_q;
endmodule

// File: tb/tb_alu_ctrl_exwb.sv
// Self-checking bench for alu_ctrl_exwb: decode table, ALU arithmetic, EX/WB capture,
// sticky flags and asynchronous reset, against a behavioural model.
module tb_alu_ctrl_exwb;
    localparam int DW = 32;
    localparam int RW = 6;

    typedef struct packed {
        logic rw, mtr, ptr, mr, mw, bn, bz, j, jm;
        logic [3:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic [6:0]    ctrl;
        logic [DW-1:0] alu, dmem, se;
        logic [RW-1:0] rd;
        logic          z, n;
    } exwb_t;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic m_z, m_n;
    exwb_t exp_exwb;

    alu_ctrl_exwb_if #(.DW(DW), .RW(RW)) bus ();
    alu_ctrl_exwb #(.DW(DW), .RW(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    ctrl_t ctrl_obs;
    exwb_t exwb_obs;
    assign ctrl_obs = {bus.RegWrt, bus.MemToReg, bus.PCtoReg, bus.MemRead, bus.MemWrt,
                       bus.BranchNeg, bus.BranchZero, bus.Jump, bus.JumpMem, bus.ALUOp};
    assign exwb_obs = {bus.RegWrt_EXWB, bus.MemToReg_EXWB, bus.PCtoReg_EXWB, bus.BranchNeg_EXWB,
                       bus.BranchZero_EXWB, bus.Jump_EXWB, bus.JumpMem_EXWB, bus.ALUout_EXWB,
                       bus.Dmemout_EXWB, bus.SEadderout_EXWB, bus.Rd_EXWB, bus.Z_EXWB, bus.N_EXWB};

    function automatic ctrl_t ref_decode(input logic [3:0] op);
        ctrl_t c = '0;
        case (op)
            4'b1111: begin c.rw = 1'b1; c.ptr = 1'b1; end
            4'b1110: begin c.rw = 1'b1; c.mr = 1'b1; c.mtr = 1'b1; end
            4'b0011: c.mw = 1'b1;
            4'b0100, 4'b0101, 4'b0110, 4'b0111: begin c.rw = 1'b1; c.aluop = op; end
            4'b1000: c.j = 1'b1;
            4'b1001: c.bz = 1'b1;
            4'b1011: c.bn = 1'b1;
            4'b1010: begin c.jm = 1'b1; c.mr = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'd4:    return a + b;
            4'd5:    return a + 32'd1;
            4'd6:    return 32'd0 - a;
            4'd7:    return a - b;
            default: return a;
        endcase
    endfunction

    // Model of one clock edge: what the EX/WB register should hold afterwards
    task automatic predict();
        logic [DW-1:0] r;
        r = ref_alu(bus.ALUOp_i, bus.A, bus.B);
        if (bus.ALUOp_i inside {4'd4, 4'd5, 4'd6, 4'd7}) begin
            m_z = (r == 32'd0);
            m_n = r[DW-1];
        end
        exp_exwb = {bus.RegWrt_i, bus.MemToReg_i, bus.PCtoReg_i, bus.BranchNeg_i, bus.BranchZero_i,
                    bus.Jump_i, bus.JumpMem_i, r, bus.Dmem_i, bus.SEadd_i, bus.Rd_i, m_z, m_n};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.opcode = 4'($urandom_range(0, 15));
        {bus.RegWrt_i, bus.MemToReg_i, bus.PCtoReg_i, bus.BranchNeg_i,
         bus.BranchZero_i, bus.Jump_i, bus.JumpMem_i} = 7'($urandom);
        bus.ALUOp_i = 4'($urandom_range(0, 15));
        bus.A       = $urandom;
        bus.B       = ($urandom_range(0, 3) == 0) ? bus.A : $urandom;
        bus.Dmem_i  = $urandom;
        bus.SEadd_i = $urandom;
        bus.Rd_i    = 6'($urandom);
    endtask

    task automatic clear_inputs();
        bus.opcode = 4'd0;
        {bus.RegWrt_i, bus.MemToReg_i, bus.PCtoReg_i, bus.BranchNeg_i,
         bus.BranchZero_i, bus.Jump_i, bus.JumpMem_i} = 7'd0;
        bus.ALUOp_i = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
        bus.Dmem_i = 32'd0; bus.SEadd_i = 32'd0; bus.Rd_i = 6'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rand_inputs();
        bus.opcode = 4'b1110;
        step(); step();
        vectors++;
        if (exwb_obs !== '0) begin
            miscompares++;
            $display("FAIL reset_exwb got %h want 0", exwb_obs);
        end
        vectors++;
        if (ctrl_obs !== ref_decode(4'b1110)) begin
            miscompares++;
            $display("FAIL reset_decode got %h want %h", ctrl_obs, ref_decode(4'b1110));
        end
        rst_n = 1'b1;
        m_z = 1'b0; m_n = 1'b0;
    endtask

    task automatic test_decode();
        for (int op = 0; op < 16; op++) begin
            bus.opcode = 4'(op);
            #1;
            vectors++;
            if (ctrl_obs !== ref_decode(4'(op))) begin
                miscompares++;
                $display("FAIL decode op=%b got %h want %h", 4'(op), ctrl_obs, ref_decode(4'(op)));
            end
        end
    endtask

    task automatic test_alu();
        logic [3:0]    t_op [10] = '{4'd4, 4'd7, 4'd7, 4'd5, 4'd6, 4'd6, 4'd6, 4'd0, 4'd2, 4'd7};
        logic [DW-1:0] t_a  [10] = '{32'd5, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000,
                                     32'h1234, 32'hDEAD, 32'd4};
        logic [DW-1:0] t_b  [10] = '{32'd3, 32'd3, 32'd5, 32'd7, 32'd9, 32'd9, 32'd9, 32'd1, 32'd1, 32'd4};
        logic [DW-1:0] t_r  [10] = '{32'd8, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
                                     32'h1234, 32'hDEAD, 32'd0};
        logic [1:0]    t_zn [10] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
        for (int i = 0; i < 10; i++) begin
            bus.ALUOp_i = t_op[i]; bus.A = t_a[i]; bus.B = t_b[i];
            #1;
            vectors++;
            if ({bus.ALUout, bus.Z_flag, bus.N_flag} !== {t_r[i], t_zn[i]}) begin
                miscompares++;
                $display("FAIL alu_dir #%0d got %h/%b%b want %h/%b", i, bus.ALUout, bus.Z_flag, bus.N_flag, t_r[i], t_zn[i]);
            end
        end
    endtask

    task automatic test_pipeline();
        clear_inputs();
        bus.ALUOp_i = 4'd4; bus.A = 32'd7; bus.B = 32'd9; bus.Rd_i = 6'd12; bus.RegWrt_i = 1'b1;
        predict();
        step();
        vectors++;
        if ({bus.ALUout_EXWB, bus.Rd_EXWB, bus.RegWrt_EXWB} !== {32'd16, 6'd12, 1'b1}) begin
            miscompares++;
            $display("FAIL pipe_add got alu=%h rd=%0d rw=%b want 16/12/1", bus.ALUout_EXWB, bus.Rd_EXWB, bus.RegWrt_EXWB);
        end
        vectors++;
        if (exwb_obs !== exp_exwb) begin
            miscompares++;
            $display("FAIL pipe_full got %h want %h", exwb_obs, exp_exwb);
        end
    endtask

    task automatic test_sticky_flags();
        clear_inputs();
        bus.ALUOp_i = 4'd7; bus.A = 32'd4; bus.B = 32'd4;
        predict(); step();
        clear_inputs();
        bus.ALUOp_i = 4'd0; bus.A = 32'h20; bus.BranchZero_i = 1'b1;
        predict(); step();
        vectors++;
        if ({bus.Z_EXWB, bus.N_EXWB, bus.ALUout_EXWB, bus.BranchZero_EXWB} !== {1'b1, 1'b0, 32'h20, 1'b1}) begin
            miscompares++;
            $display("FAIL sticky_brz got z=%b n=%b alu=%h bz=%b want 1/0/20/1", bus.Z_EXWB, bus.N_EXWB, bus.ALUout_EXWB, bus.BranchZero_EXWB);
        end
        // negative result then a BRN with a non-arithmetic opcode 1100
        bus.ALUOp_i = 4'd6; bus.A = 32'd3; bus.BranchZero_i = 1'b0;
        predict(); step();
        bus.ALUOp_i = 4'b1100; bus.A = 32'd0; bus.BranchNeg_i = 1'b1;
        predict(); step();
        vectors++;
        if (exwb_obs !== exp_exwb || bus.N_EXWB !== 1'b1 || bus.Z_EXWB !== 1'b0) begin
            miscompares++;
            $display("FAIL sticky_brn got %h want %h", exwb_obs, exp_exwb);
        end
    endtask

    task automatic test_reset_midrun();
        rand_inputs();
        bus.RegWrt_i = 1'b1; bus.ALUOp_i = 4'd5; bus.A = 32'hFFFF_FFFF; bus.Rd_i = 6'd33;
        predict(); step();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (exwb_obs !== '0) begin
            miscompares++;
            $display("FAIL reset_async got %h want 0", exwb_obs);
        end
        m_z = 1'b0; m_n = 1'b0;
        step();
        vectors++;
        if (exwb_obs !== '0) begin
            miscompares++;
            $display("FAIL reset_held got %h want 0", exwb_obs);
        end
        rst_n = 1'b1;
        rand_inputs();
        bus.ALUOp_i = 4'd0; bus.A = 32'h55;
        predict(); step();
        vectors++;
        if (exwb_obs !== exp_exwb) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", exwb_obs, exp_exwb);
        end
    endtask

    task automatic test_mem_path();
        clear_inputs();
        bus.Dmem_i = 32'hABCD; bus.MemToReg_i = 1'b1; bus.RegWrt_i = 1'b1; bus.Rd_i = 6'd5;
        bus.SEadd_i = 32'h1000_0004; bus.JumpMem_i = 1'b1;
        predict(); step();
        vectors++;
        if ({bus.Dmemout_EXWB, bus.MemToReg_EXWB, bus.SEadderout_EXWB, bus.JumpMem_EXWB} !==
            {32'hABCD, 1'b1, 32'h1000_0004, 1'b1}) begin
            miscompares++;
            $display("FAIL mem_path got dmem=%h mtr=%b se=%h jm=%b want abcd/1/10000004/1",
                     bus.Dmemout_EXWB, bus.MemToReg_EXWB, bus.SEadderout_EXWB, bus.JumpMem_EXWB);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            #1;
            vectors++;
            if ({bus.ALUout, bus.Z_flag, bus.N_flag} !==
                {ref_alu(bus.ALUOp_i, bus.A, bus.B), ref_alu(bus.ALUOp_i, bus.A, bus.B) == 32'd0,
                 ref_alu(bus.ALUOp_i, bus.A, bus.B) >= 32'h8000_0000}) begin
                miscompares++;
                $display("FAIL rand_alu op=%b a=%h b=%h got %h", bus.ALUOp_i, bus.A, bus.B, bus.ALUout);
            end
            vectors++;
            if (ctrl_obs !== ref_decode(bus.opcode)) begin
                miscompares++;
                $display("FAIL rand_decode op=%b got %h want %h", bus.opcode, ctrl_obs, ref_decode(bus.opcode));
            end
            predict(); step();
            vectors++;
            if (exwb_obs !== exp_exwb) begin
                miscompares++;
                $display("FAIL rand_exwb #%0d got %h want %h", i, exwb_obs, exp_exwb);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_decode();
        test_alu();
        test_pipeline();
        test_sticky_flags();
        test_reset_midrun();
        test_mem_path();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout after %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
